// File: rtl/tcm3_pkg.sv
// Shared constants, FSM encoding and the fixed 9-entry partial-product schedule
// for the area-optimised 3-way GF(2) polynomial multiplier.
package tcm3_pkg;

    localparam int N   = 409;
    localparam int K   = (N + 2) / 3;
    localparam int C_W = 2 * N;
    localparam int P_W = 2 * K - 1;
    localparam int NPP = 9;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        DONE
    } state_t;

    // Schedule ROM, indexed by pp_idx: product a_i*b_j lands at weight w = i+j.
    localparam logic [1:0] SCHED_I [NPP] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
    localparam logic [1:0] SCHED_J [NPP] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2};
    localparam logic [2:0] SCHED_W [NPP] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};

    // Top limb is shorter than K; zero-extend the operand so every limb is K bits.
    function automatic logic [K-1:0] limb(input logic [N-1:0] v, input logic [1:0] sel);
        logic [3*K-1:0] ext;
        ext = {{(3*K-N){1'b0}}, v};
        return ext[sel*K +: K];
    endfunction

endpackage

// File: rtl/gf2_serial_mul.sv
// Bit-serial carry-less KxK multiplier: one y bit per cycle, LSB first,
// K cycles per product; done is high during the cycle that retires the last bit.
module gf2_serial_mul #(
    parameter int K = 137
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K-1:0]   x,
    input  logic [K-1:0]   y,
    output logic           done,
    output logic [2*K-2:0] p
);

    localparam int CNT_W = $clog2(K);
    localparam int P_W   = 2 * K - 1;

    logic [CNT_W-1:0] cnt;
    logic             run;

    assign done = run && (cnt == CNT_W'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            p   <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (y[cnt])
                p <= p ^ (P_W'(x) << cnt);
            cnt <= cnt + 1'b1;
            if (done)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/tcm3_gf2_mul_scheduler.sv
// Sequences one shared serial multiplier through the nine limb products of a
// 3-way split and XOR-accumulates them into the 2N-bit result; constant-time.
module tcm3_gf2_mul_scheduler
    import tcm3_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [C_W-1:0] c,
    output logic           busy,
    output logic [3:0]     pp_idx
);

    state_t         state;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [C_W-1:0] acc;

    logic           accept;
    logic           last_pp;
    logic           mul_start;
    logic           mul_done;
    logic [K-1:0]   mul_x;
    logic [K-1:0]   mul_y;
    logic [P_W-1:0] pp;
    logic [9:0]     sh;

    assign accept    = in_valid && in_ready;
    assign last_pp   = (pp_idx == 4'(NPP - 1));
    // The ACC cycle also restarts the sub-multiplier, so each product costs K+1 cycles.
    assign mul_start = accept || (state == ACC && !last_pp);
    assign mul_x     = limb(a_r, SCHED_I[pp_idx]);
    assign mul_y     = limb(b_r, SCHED_J[pp_idx]);
    assign sh        = 10'(SCHED_W[pp_idx]) * 10'(K);

    gf2_serial_mul #(.K(K)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .x     (mul_x),
        .y     (mul_y),
        .done  (mul_done),
        .p     (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            c         <= '0;
            pp_idx    <= '0;
            acc       <= '0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r      <= a;
                        b_r      <= b;
                        acc      <= '0;
                        pp_idx   <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    if (mul_done)
                        state <= ACC;
                end
                ACC: begin
                    acc <= acc ^ (C_W'(pp) << sh);
                    if (last_pp) begin
                        state <= DONE;
                    end else begin
                        pp_idx <= pp_idx + 4'd1;
                        state  <= MUL;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        c         <= acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        pp_idx    <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcm3_gf2_mul_scheduler.sv
// Self-checking bench: directed limb/latency cases plus random traffic checked
// against a plain shift-and-XOR carry-less multiply model.
module tb_tcm3_gf2_mul_scheduler;

    localparam int N   = 409;
    localparam int C_W = 2 * N;
    localparam int LAT = 1243;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [C_W-1:0] c;
    logic [3:0]     pp_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tcm3_gf2_mul_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy),
        .pp_idx    (pp_idx)
    );

    function automatic logic [C_W-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [C_W-1:0] r = '0;
        for (int i = 0; i < N; i++)
            if (x[i]) r = r ^ (C_W'(y) << i);
        return r;
    endfunction

    function automatic logic [N-1:0] rnd_op();
        logic [N-1:0] v = '0;
        for (int k = 0; k < N; k += 32)
            v = (v << 32) | N'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair, then scrambles a/b (and optionally spams in_valid)
    // while waiting for out_valid under a cycle budget.
    task automatic start_and_wait(input logic [N-1:0] ta, input logic [N-1:0] tb_, input bit spam,
                                  output bit acc_ok, output int lat, output bit busy_ok);
        acc_ok = in_ready;
        a = ta;
        b = tb_;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = rnd_op();
        b = rnd_op();
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 2 * LAT) begin
            if (!busy || in_ready) busy_ok = 1'b0;
            if (spam) begin
                in_valid = 1'($urandom);
                a = rnd_op();
                b = rnd_op();
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        a = rnd_op();
        b = rnd_op();
        repeat (3) begin
            tick();
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_in_rst: got %0b want 0", busy); end
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++;
        if (c !== '0) begin bad++; $display("FAIL reset_c: got %0h want 0", c); end
        total++;
        if (pp_idx !== 4'd0) begin bad++; $display("FAIL reset_pp_idx: got %0d want 0", pp_idx); end
    endtask

    task automatic test_basic();
        bit ok_acc, bok;
        int lat;
        logic [C_W-1:0] exp = C_W'(1);
        start_and_wait(N'(1), N'(1), 1'b0, ok_acc, lat, bok);
        total++;
        if (ok_acc !== 1'b1) begin bad++; $display("FAIL basic_accept: in_ready got %0b want 1", ok_acc); end
        total++;
        if (lat != LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        total++;
        if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy: busy/in_ready wrong while running"); end
        total++;
        if (c !== exp) begin bad++; $display("FAIL basic_c: got %0h want %0h", c, exp); end
        handshake();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL basic_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_limb();
        bit ok_acc, bok;
        int lat;
        int ia [2] = '{408, 136};
        int ib [2] = '{408, 137};
        int ic [2] = '{816, 273};
        for (int t = 0; t < 2; t++) begin
            logic [N-1:0] x = '0;
            logic [N-1:0] y = '0;
            logic [C_W-1:0] exp = '0;
            x[ia[t]] = 1'b1;
            y[ib[t]] = 1'b1;
            exp[ic[t]] = 1'b1;
            start_and_wait(x, y, 1'b0, ok_acc, lat, bok);
            total++;
            if (c !== exp) begin bad++; $display("FAIL limb_c%0d: got %0h want %0h", t, c, exp); end
            total++;
            if (lat != LAT) begin bad++; $display("FAIL limb_latency%0d: got %0d want %0d", t, lat, LAT); end
            handshake();
        end
    endtask

    task automatic test_allones();
        bit ok_acc, bok;
        int lat;
        logic [C_W-1:0] exp = '0;
        for (int i = 0; i <= 816; i += 2) exp[i] = 1'b1;
        start_and_wait('1, '1, 1'b0, ok_acc, lat, bok);
        total++;
        if (c !== exp) begin bad++; $display("FAIL allones_c: got %0h want %0h", c, exp); end
        handshake();
        start_and_wait('0, rnd_op(), 1'b0, ok_acc, lat, bok);
        total++;
        if (c !== '0) begin bad++; $display("FAIL zero_c: got %0h want 0", c); end
        total++;
        if (lat != LAT) begin bad++; $display("FAIL zero_latency: got %0d want %0d", lat, LAT); end
        handshake();
    endtask

    task automatic test_backpressure();
        bit ok_acc, bok;
        int lat;
        logic [N-1:0] x = rnd_op();
        logic [N-1:0] y = rnd_op();
        logic [C_W-1:0] exp = clmul(x, y);
        start_and_wait(x, y, 1'b0, ok_acc, lat, bok);
        repeat (50) begin
            tick();
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
            total++;
            if (c !== exp) begin bad++; $display("FAIL bp_c: got %0h want %0h", c, exp); end
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
        end
        handshake();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
        x = rnd_op();
        y = rnd_op();
        exp = clmul(x, y);
        start_and_wait(x, y, 1'b0, ok_acc, lat, bok);
        total++;
        if (ok_acc !== 1'b1) begin bad++; $display("FAIL bp_next_accept: got %0b want 1", ok_acc); end
        total++;
        if (c !== exp) begin bad++; $display("FAIL bp_next_c: got %0h want %0h", c, exp); end
        handshake();
    endtask

    task automatic test_rst_mid();
        bit ok_acc, bok;
        int lat, n;
        logic [N-1:0] x = rnd_op();
        logic [N-1:0] y = rnd_op();
        logic [C_W-1:0] exp;
        a = x;
        b = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (pp_idx != 4'd4 && n < 2 * LAT) begin tick(); n++; end
        total++;
        if (pp_idx !== 4'd4) begin bad++; $display("FAIL rstmid_reach: pp_idx got %0d want 4", pp_idx); end
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL rstmid_state: out_valid=%0b in_ready=%0b busy=%0b want 0/1/0", out_valid, in_ready, busy); end
        total++;
        if (pp_idx !== 4'd0) begin bad++; $display("FAIL rstmid_pp_idx: got %0d want 0", pp_idx); end
        x = rnd_op();
        y = rnd_op();
        exp = clmul(x, y);
        start_and_wait(x, y, 1'b0, ok_acc, lat, bok);
        total++;
        if (c !== exp) begin bad++; $display("FAIL rstmid_fresh_c: got %0h want %0h", c, exp); end
        total++;
        if (lat != LAT) begin bad++; $display("FAIL rstmid_latency: got %0d want %0d", lat, LAT); end
        handshake();
    endtask

    task automatic test_back_to_back();
        bit ok_acc, bok, took;
        int lat, guard;
        logic [N-1:0] x, y;
        logic [C_W-1:0] exp, prev;
        for (int op = 0; op < 40; op++) begin
            repeat ($urandom_range(0, 2)) tick();
            x = rnd_op();
            y = rnd_op();
            if (op % 10 == 3) x = '1;
            if (op % 10 == 7) y = N'(1) << $urandom_range(0, N - 1);
            exp = clmul(x, y);
            start_and_wait(x, y, 1'b1, ok_acc, lat, bok);
            total++;
            if (ok_acc !== 1'b1) begin bad++; $display("FAIL b2b_accept[%0d]: got %0b want 1", op, ok_acc); end
            total++;
            if (lat != LAT) begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", op, lat, LAT); end
            total++;
            if (bok !== 1'b1) begin bad++; $display("FAIL b2b_busy[%0d]: busy/in_ready wrong while running", op); end
            total++;
            if (c !== exp) begin bad++; $display("FAIL b2b_c[%0d]: got %0h want %0h", op, c, exp); end
            took = 1'b0;
            guard = 0;
            while (!took) begin
                out_ready = (guard >= 16) ? 1'b1 : 1'($urandom);
                took = out_ready;
                prev = c;
                tick();
                guard++;
                if (!took) begin
                    total++;
                    if (out_valid !== 1'b1 || c !== prev)
                        begin bad++; $display("FAIL b2b_hold[%0d]: out_valid=%0b c=%0h want 1 c=%0h", op, out_valid, c, prev); end
                end
            end
            out_ready = 1'b0;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                begin bad++; $display("FAIL b2b_release[%0d]: out_valid=%0b in_ready=%0b want 0/1", op, out_valid, in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_limb();
        test_allones();
        test_backpressure();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
